// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer: slice width,
// controller state encoding and the signed-overflow rule.
package byte_serial_add_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrlStateT;

  // Overflow when both addends share a sign and the result sign differs from it.
  function automatic logic signedOverflow(input logic aMsb, input logic bMsb, input logic sumMsb);
    return (aMsb == bMsb) && (sumMsb != aMsb);
  endfunction

endpackage

// File: rtl/byte_serial_add_ctrl.sv
// Streams NUM_BYTES byte slices of A and effective B through an external 8-bit
// adder, LSB first, carrying between slices in a register; one result per op.
module byte_serial_add_ctrl
  import byte_serial_add_ctrl_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_a,
  input  logic [8*NUM_BYTES-1:0] in_b,
  input  logic                   in_sub,
  output logic [7:0]             add_a,
  output logic [7:0]             add_b,
  output logic                   add_cin,
  input  logic [7:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic [1:0]             dbgState
);

  localparam int W     = BYTE_W * NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. in_ready is high only in IDLE; out_valid is high only in DONE and the
  // result is held unchanged until the edge where out_ready is seen high.

  ctrlStateT        state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     aR;
  logic [W-1:0]     bR;
  logic [W-1:0]     sumR;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      aR    <= '0;
      bR    <= '0;
      sumR  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            aR    <= in_a;
            bR    <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            idx   <= '0;
            sumR  <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sumR[BYTE_W*idx +: BYTE_W] <= add_sum;
          carry                      <= add_cout;
          idx                        <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic running;
  assign running = (state == ST_RUN);

  assign add_a   = running ? aR[BYTE_W*idx +: BYTE_W] : '0;
  assign add_b   = running ? bR[BYTE_W*idx +: BYTE_W] : '0;
  assign add_cin = running ? carry : 1'b0;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_sum   = sumR;
  assign out_cout  = carry;
  assign out_ovf   = signedOverflow(aR[W-1], bR[W-1], sumR[W-1]);
  assign dbgState  = state;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Bench for byte_serial_add_ctrl: directed vector table, multi-cycle corner
// sequences, then random ops scored against a plain-arithmetic reference.
module tb_byte_serial_add_ctrl;

  localparam int NUM_BYTES = 4;
  localparam int W = 8 * NUM_BYTES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, add_cin, add_cout, out_valid, out_cout, out_ovf;
  logic [7:0]   add_a, add_b, add_sum;
  logic [W-1:0] out_sum;
  logic [1:0]   dbgState;

  int nChecks = 0;
  int nFail = 0;
  logic [W+1:0] expQ[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vecT;

  vecT vecs[8];

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  // The external 8-bit ripple adder the sequencer drives.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  byte_serial_add_ctrl #(.NUM_BYTES(NUM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .dbgState(dbgState)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Result packed as {sum, cout, ovf}.
  function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
    longint sa, sb, ua, ub, res, lim;
    logic [W-1:0] r;
    logic c, v;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    lim = longint'(1) << (W - 1);
    res = sub ? (sa - sb) : (sa + sb);
    v   = (res >= lim) || (res < -lim);
    r   = res[W-1:0];
    c   = sub ? (ua >= ub) : ((ua + ub) >= (lim << 1));
    return {r, c, v};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      if (nFail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sendOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input bit noisy);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready before accept", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = sub;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 50) begin
      check("in_ready low while busy", in_ready, 0);
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = $urandom;
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("latency", lat, NUM_BYTES);
  endtask

  task automatic recvOp(input logic [W+1:0] exp, input int hold, input string tag);
    for (int i = 0; i <= hold; i++) begin
      check({tag, " out_valid"}, out_valid, 1);
      check({tag, " out_sum"}, out_sum, exp[W+1:2]);
      check({tag, " out_cout"}, out_cout, exp[1]);
      check({tag, " out_ovf"}, out_ovf, exp[0]);
      if (i < hold) begin
        check({tag, " in_ready in DONE"}, in_ready, 0);
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after accept"}, out_valid, 0);
    check({tag, " in_ready after accept"}, in_ready, 1);
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid within bound", out_valid, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    logic [W+1:0] e;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset state", dbgState, 0);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_sum", out_sum, 0);
    check("reset out_cout", out_cout, 0);
    check("reset out_ovf", out_ovf, 0);
    check("idle add_a", add_a, 0);
    check("idle add_cin", add_cin, 0);

    // directed table
    foreach (vecs[i]) begin
      sendOp(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0);
      recvOp({vecs[i].sum, vecs[i].cout, vecs[i].ovf}, i % 3, $sformatf("vec%0d", i));
    end

    // long backpressure: result and in_ready stable for 10 cycles
    sendOp(32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b0);
    recvOp({32'hDFAF_C1F3, 1'b0, 1'b0}, 10, "hold10");

    // reset in the middle of RUN, at idx 2
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'h1122_3344;
    in_b = 32'h0101_0101;
    in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("run byte0 add_a", add_a, 8'h44);
    check("run byte0 add_b", add_b, 8'h01);
    @(negedge clk);
    check("run byte1 add_a", add_a, 8'h33);
    @(negedge clk);
    check("run byte2 add_a", add_a, 8'h22);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun reset state", dbgState, 0);
    check("midrun reset out_valid", out_valid, 0);
    check("midrun reset in_ready", in_ready, 1);
    check("midrun reset out_sum", out_sum, 0);
    check("midrun reset out_cout", out_cout, 0);
    check("midrun reset out_ovf", out_ovf, 0);
    check("midrun reset add_a", add_a, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no partial result", out_valid, 0);
    end

    // in_valid pulse during RUN is ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'h0102_0304;
    in_b = 32'h1020_3040;
    in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'h1234_5678;
    in_b = 32'h0000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    waitValid();
    recvOp({32'h1122_3344, 1'b0, 1'b0}, 1, "ignore pulse");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no second result", out_valid, 0);
    end

    // random ops with backpressure and junk on the input side while busy
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h7FFF_FFFF;
        1: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      rs = 1'($urandom_range(0, 1));
      expQ.push_back(refModel(ra, rb, rs));
      sendOp(ra, rb, rs, 1'b1);
      e = expQ.pop_front();
      recvOp(e, $urandom_range(0, 3), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
